regs_wb_arb: RTL and testbench

REGS_WB_ARB -- requirements
Module: regs_wb_arb

---
 rtl/regs_wb_arb_pkg.sv | 26 ++
 rtl/regs_wb_arb_rr_arb3.sv | 41 ++++
 rtl/regs_wb_arb.sv | 143 ++++++++++++++
 tb/tb_regs_wb_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_wb_arb_pkg.sv
// regs_wb_arb_pkg
// Shared definitions for the register-file write-back arbiter:
//   - default register address / data widths
//   - ZeroReg: hard-wired zero register; writes to it are accepted but
//     never reach the register file
//   - requester indices into request / grant / busy vectors
//   - priority pointer encoding used by the round-robin build
package regs_wb_arb_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_DATA_WIDTH = 32;
   localparam int ZeroReg        = 0;

   localparam int WB_EX  = 0;
   localparam int WB_LSU = 1;
   localparam int WB_MDU = 2;
   localparam int WB_NUM = 3;

   // Encoding 2'd3 is unreachable; consumers decode it as P_EX.
   typedef enum logic [1:0] {
      P_EX  = 2'd0,
      P_LSU = 2'd1,
      P_MDU = 2'd2
   } wb_ptr_e;

endpackage

// File: rtl/regs_wb_arb_rr_arb3.sv
// rr_arb3
// Combinational 3-way priority picker. The pointer names the requester
// with highest priority; the search continues upward and wraps mdu->ex.
// Ports:
//   req  [2:0]  request vector {mdu, lsu, ex}
//   ptr         highest-priority requester (2'd3 behaves as P_EX)
//   gnt  [2:0]  one-hot grant, zero when no request
module rr_arb3
   import regs_wb_arb_pkg::*;
(
   input  logic [WB_NUM-1:0] req,
   input  wb_ptr_e           ptr,
   output logic [WB_NUM-1:0] gnt
);

   // Priority search starting at the requester named by ptr
   always_comb begin
      gnt = 3'b000;
      case (ptr)
         P_LSU: begin
            if (req[WB_LSU])      gnt[WB_LSU] = 1'b1;
            else if (req[WB_MDU]) gnt[WB_MDU] = 1'b1;
            else if (req[WB_EX])  gnt[WB_EX]  = 1'b1;
            else                  gnt = 3'b000;
         end
         P_MDU: begin
            if (req[WB_MDU])      gnt[WB_MDU] = 1'b1;
            else if (req[WB_EX])  gnt[WB_EX]  = 1'b1;
            else if (req[WB_LSU]) gnt[WB_LSU] = 1'b1;
            else                  gnt = 3'b000;
         end
         default: begin
            if (req[WB_EX])       gnt[WB_EX]  = 1'b1;
            else if (req[WB_LSU]) gnt[WB_LSU] = 1'b1;
            else if (req[WB_MDU]) gnt[WB_MDU] = 1'b1;
            else                  gnt = 3'b000;
         end
      endcase
   end

endmodule

// File: rtl/regs_wb_arb.sv
// regs_wb_arb
// Arbitrates three write-back requesters (ex, lsu, mdu) onto the single
// register-file write port. Grants are combinational; the selected
// address/data are registered, so the write appears one cycle after the
// handshake. Writes to ZeroReg are granted but leave we_o low.
// Build option: WB_ARB_RR_EN defined -> round-robin pointer that advances
// past each granted requester; undefined -> fixed priority ex > lsu > mdu.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   <k>_valid_i/_waddr_i/_wdata_i write-back request per requester
//   <k>_ready_o                   grant (transfer on valid & ready)
//   we_o, waddr_o, wdata_o        registered register-file write port
//   busy_o [2:0]                  {mdu, lsu, ex} valid but not granted
module regs_wb_arb
   import regs_wb_arb_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = regs_wb_arb_pkg::REG_ADDR_WIDTH,
   parameter int REG_DATA_WIDTH = regs_wb_arb_pkg::REG_DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ex_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] ex_waddr_i,
   input  logic [REG_DATA_WIDTH-1:0] ex_wdata_i,
   output logic                      ex_ready_o,
   input  logic                      lsu_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_waddr_i,
   input  logic [REG_DATA_WIDTH-1:0] lsu_wdata_i,
   output logic                      lsu_ready_o,
   input  logic                      mdu_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] mdu_waddr_i,
   input  logic [REG_DATA_WIDTH-1:0] mdu_wdata_i,
   output logic                      mdu_ready_o,
   output logic                      we_o,
   output logic [REG_ADDR_WIDTH-1:0] waddr_o,
   output logic [REG_DATA_WIDTH-1:0] wdata_o,
   output logic [2:0]                busy_o
);

   logic [WB_NUM-1:0]         req_s;
   logic [WB_NUM-1:0]         gnt_s;
   wb_ptr_e                   ptr_s;
   logic [REG_ADDR_WIDTH-1:0] sel_waddr_s;
   logic [REG_DATA_WIDTH-1:0] sel_wdata_s;
   logic                      we_r;
   logic [REG_ADDR_WIDTH-1:0] waddr_r;
   logic [REG_DATA_WIDTH-1:0] wdata_r;

   // Requests are masked during reset so nothing is granted in that cycle
   always_comb begin
      if (rst) begin
         req_s = 3'b000;
      end else begin
         req_s = {mdu_valid_i, lsu_valid_i, ex_valid_i};
      end
   end

`ifdef WB_ARB_RR_EN
   wb_ptr_e ptr_r;
   wb_ptr_e ptr_nxt_s;

   // Priority pointer state register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= P_EX;
      end else begin
         ptr_r <= ptr_nxt_s;
      end
   end

   // Next pointer: the requester after the one just granted, else hold
   always_comb begin
      if (gnt_s[WB_EX]) begin
         ptr_nxt_s = P_LSU;
      end else if (gnt_s[WB_LSU]) begin
         ptr_nxt_s = P_MDU;
      end else if (gnt_s[WB_MDU]) begin
         ptr_nxt_s = P_EX;
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   assign ptr_s = ptr_r;
`else
   // Fixed priority is the picker with the pointer tied to ex
   assign ptr_s = P_EX;
`endif

   rr_arb3 u_rr_arb3 (
      .req (req_s),
      .ptr (ptr_s),
      .gnt (gnt_s)
   );

   // Grant and waiting flags driven straight from the picker result
   always_comb begin
      ex_ready_o  = gnt_s[WB_EX];
      lsu_ready_o = gnt_s[WB_LSU];
      mdu_ready_o = gnt_s[WB_MDU];
      busy_o      = req_s & ~gnt_s;
   end

   // Address/data of the granted requester
   always_comb begin
      sel_waddr_s = '0;
      sel_wdata_s = '0;
      if (gnt_s[WB_EX]) begin
         sel_waddr_s = ex_waddr_i;
         sel_wdata_s = ex_wdata_i;
      end else if (gnt_s[WB_LSU]) begin
         sel_waddr_s = lsu_waddr_i;
         sel_wdata_s = lsu_wdata_i;
      end else if (gnt_s[WB_MDU]) begin
         sel_waddr_s = mdu_waddr_i;
         sel_wdata_s = mdu_wdata_i;
      end else begin
         sel_waddr_s = '0;
         sel_wdata_s = '0;
      end
   end

   // Write port register; address/data hold when idle, zero-reg writes
   // update address/data but do not raise the enable
   always_ff @(posedge clk) begin
      if (rst) begin
         we_r    <= 1'b0;
         waddr_r <= '0;
         wdata_r <= '0;
      end else if (|gnt_s) begin
         we_r    <= (sel_waddr_s != REG_ADDR_WIDTH'(ZeroReg));
         waddr_r <= sel_waddr_s;
         wdata_r <= sel_wdata_s;
      end else begin
         we_r    <= 1'b0;
      end
   end

   assign we_o    = we_r;
   assign waddr_o = waddr_r;
   assign wdata_o = wdata_r;

endmodule

// File: tb/tb_regs_wb_arb.sv
// tb_regs_wb_arb
// Directed self-checking bench for regs_wb_arb. Inputs change 1 time unit
// after the rising edge; outputs are compared 1 unit later, well before
// the next edge. Builds with or without WB_ARB_RR_EN.
module tb_regs_wb_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, lsu_valid, mdu_valid;
   logic [4:0]  ex_waddr, lsu_waddr, mdu_waddr;
   logic [31:0] ex_wdata, lsu_wdata, mdu_wdata;
   logic        ex_ready, lsu_ready, mdu_ready;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [2:0]  busy;
   logic [31:0] rf [0:31];

   int checks = 0;
   int errors = 0;

   regs_wb_arb dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid_i  (ex_valid),
      .ex_waddr_i  (ex_waddr),
      .ex_wdata_i  (ex_wdata),
      .ex_ready_o  (ex_ready),
      .lsu_valid_i (lsu_valid),
      .lsu_waddr_i (lsu_waddr),
      .lsu_wdata_i (lsu_wdata),
      .lsu_ready_o (lsu_ready),
      .mdu_valid_i (mdu_valid),
      .mdu_waddr_i (mdu_waddr),
      .mdu_wdata_i (mdu_wdata),
      .mdu_ready_o (mdu_ready),
      .we_o        (we),
      .waddr_o     (waddr),
      .wdata_o     (wdata),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   // Register-file model fed by the write port
   always @(posedge clk) begin
      if (we === 1'b1) rf[waddr] <= wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ex_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
      ex_waddr = 5'd0; lsu_waddr = 5'd0; mdu_waddr = 5'd0;
      ex_wdata = 32'd0; lsu_wdata = 32'd0; mdu_wdata = 32'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ex_valid = 1'b1; lsu_valid = 1'b1; mdu_valid = 1'b1;
      ex_waddr = 5'd3; lsu_waddr = 5'd4; mdu_waddr = 5'd5;
      ex_wdata = 32'h11; lsu_wdata = 32'h22; mdu_wdata = 32'h33;
      tick();
      tick();
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready} !== 3'b000) begin
         errors++; $display("FAIL reset_ready got %b want 000", {mdu_ready, lsu_ready, ex_ready});
      end
      checks++;
      if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", busy); end
      checks++;
      if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
      checks++;
      if (waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", waddr); end
      checks++;
      if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata); end
      clear_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready} !== 3'b001) begin
         errors++; $display("FAIL single_ready got %b want 001", {mdu_ready, lsu_ready, ex_ready});
      end
      checks++;
      if (we !== 1'b0) begin errors++; $display("FAIL single_we_early got %b want 0", we); end
      tick();
      ex_valid = 1'b0;
      #1;
      checks++;
      if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         errors++; $display("FAIL single_write got we=%b a=%0d d=%h want we=1 a=5 d=deadbeef", we, waddr, wdata);
      end
      tick();
      #1;
      checks++;
      if ({we, waddr, wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
         errors++; $display("FAIL single_hold got we=%b a=%0d d=%h want we=0 a=5 d=deadbeef", we, waddr, wdata);
      end
   endtask

   task automatic test_contention();
      clear_inputs();
      rst = 1'b1;
      ex_valid = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h11;
      lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'h22;
      mdu_valid = 1'b1; mdu_waddr = 5'd3; mdu_wdata = 32'h33;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready, busy} !== {3'b001, 3'b110}) begin
         errors++; $display("FAIL cont_c1 got rdy=%b busy=%b want rdy=001 busy=110", {mdu_ready, lsu_ready, ex_ready}, busy);
      end
      checks++;
      if (we !== 1'b0) begin errors++; $display("FAIL cont_no_write_after_reset got %b want 0", we); end
      tick();
      ex_valid = 1'b0;
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready, busy} !== {3'b010, 3'b100}) begin
         errors++; $display("FAIL cont_c2 got rdy=%b busy=%b want rdy=010 busy=100", {mdu_ready, lsu_ready, ex_ready}, busy);
      end
      checks++;
      if ({we, waddr, wdata} !== {1'b1, 5'd1, 32'h11}) begin
         errors++; $display("FAIL cont_w1 got we=%b a=%0d d=%h want we=1 a=1 d=11", we, waddr, wdata);
      end
      tick();
      lsu_valid = 1'b0;
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready, busy} !== {3'b100, 3'b000}) begin
         errors++; $display("FAIL cont_c3 got rdy=%b busy=%b want rdy=100 busy=000", {mdu_ready, lsu_ready, ex_ready}, busy);
      end
      checks++;
      if ({we, waddr, wdata} !== {1'b1, 5'd2, 32'h22}) begin
         errors++; $display("FAIL cont_w2 got we=%b a=%0d d=%h want we=1 a=2 d=22", we, waddr, wdata);
      end
      tick();
      mdu_valid = 1'b0;
      #1;
      checks++;
      if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h33}) begin
         errors++; $display("FAIL cont_w3 got we=%b a=%0d d=%h want we=1 a=3 d=33", we, waddr, wdata);
      end
      tick();
      #1;
      checks++;
      if (we !== 1'b0) begin errors++; $display("FAIL cont_idle_we got %b want 0", we); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'h12345678;
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready} !== 3'b010) begin
         errors++; $display("FAIL zero_ready got %b want 010", {mdu_ready, lsu_ready, ex_ready});
      end
      tick();
      lsu_valid = 1'b0;
      #1;
      checks++;
      if ({we, waddr, wdata} !== {1'b0, 5'd0, 32'h12345678}) begin
         errors++; $display("FAIL zero_write got we=%b a=%0d d=%h want we=0 a=0 d=12345678", we, waddr, wdata);
      end
   endtask

   task automatic test_same_addr();
      do_reset();
      ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h1;
      mdu_valid = 1'b1; mdu_waddr = 5'd7; mdu_wdata = 32'h2;
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready, busy} !== {3'b001, 3'b100}) begin
         errors++; $display("FAIL same_c1 got rdy=%b busy=%b want rdy=001 busy=100", {mdu_ready, lsu_ready, ex_ready}, busy);
      end
      tick();
      ex_valid = 1'b0;
      #1;
      checks++;
      if ({mdu_ready, we, waddr, wdata} !== {1'b1, 1'b1, 5'd7, 32'h1}) begin
         errors++; $display("FAIL same_w1 got mrdy=%b we=%b a=%0d d=%h want mrdy=1 we=1 a=7 d=1", mdu_ready, we, waddr, wdata);
      end
      tick();
      mdu_valid = 1'b0;
      #1;
      checks++;
      if ({we, waddr, wdata} !== {1'b1, 5'd7, 32'h2}) begin
         errors++; $display("FAIL same_w2 got we=%b a=%0d d=%h want we=1 a=7 d=2", we, waddr, wdata);
      end
      tick();
      #1;
      checks++;
      if (rf[7] !== 32'h2) begin errors++; $display("FAIL same_rf7 got %h want 2", rf[7]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      lsu_valid = 1'b1; lsu_waddr = 5'd9;  lsu_wdata = 32'h99;
      mdu_valid = 1'b1; mdu_waddr = 5'd10; mdu_wdata = 32'hAA;
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready} !== 3'b010) begin
         errors++; $display("FAIL mid_pre got %b want 010", {mdu_ready, lsu_ready, ex_ready});
      end
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready, busy} !== 6'b000000) begin
         errors++; $display("FAIL mid_rst got rdy=%b busy=%b want 000 000", {mdu_ready, lsu_ready, ex_ready}, busy);
      end
      tick();
      rst = 1'b0;
      lsu_valid = 1'b0;
      ex_valid = 1'b1; ex_waddr = 5'd12; ex_wdata = 32'hCC;
      #1;
      checks++;
      if (we !== 1'b0) begin errors++; $display("FAIL mid_we_after got %b want 0", we); end
      checks++;
      if ({mdu_ready, lsu_ready, ex_ready, busy} !== {3'b001, 3'b100}) begin
         errors++; $display("FAIL mid_first got rdy=%b busy=%b want rdy=001 busy=100", {mdu_ready, lsu_ready, ex_ready}, busy);
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if ({we, waddr, wdata} !== {1'b1, 5'd12, 32'hCC}) begin
         errors++; $display("FAIL mid_write got we=%b a=%0d d=%h want we=1 a=12 d=cc", we, waddr, wdata);
      end
   endtask

   // Round-robin build alternates ex/lsu; fixed build grants ex every cycle
   task automatic test_priority();
      logic [2:0] exp_g;
      logic [4:0] prev_a;
      do_reset();
      ex_valid = 1'b1;  ex_waddr = 5'd4;  ex_wdata = 32'h40;
      lsu_valid = 1'b1; lsu_waddr = 5'd6; lsu_wdata = 32'h60;
      prev_a = 5'd0;
      for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_RR_EN
         exp_g = (i % 2 == 0) ? 3'b001 : 3'b010;
`else
         exp_g = 3'b001;
`endif
         #1;
         checks++;
         if ({mdu_ready, lsu_ready, ex_ready} !== exp_g) begin
            errors++; $display("FAIL prio_grant c%0d got %b want %b", i, {mdu_ready, lsu_ready, ex_ready}, exp_g);
         end
         checks++;
         if (busy !== (3'b011 & ~exp_g)) begin
            errors++; $display("FAIL prio_busy c%0d got %b want %b", i, busy, 3'b011 & ~exp_g);
         end
         if (i > 0) begin
            checks++;
            if ({we, waddr} !== {1'b1, prev_a}) begin
               errors++; $display("FAIL prio_write c%0d got we=%b a=%0d want we=1 a=%0d", i, we, waddr, prev_a);
            end
         end
         prev_a = (exp_g == 3'b001) ? 5'd4 : 5'd6;
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_single();
      test_contention();
      test_zero_reg();
      test_same_addr();
      test_reset_mid();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
